// File: rtl/mux_scan_nx1.sv
// mux_scan_nx1: N-to-1 channel selector; manual select or timed auto-scan rotation.
// Latency: 1 cycle from data_in/sel_in/mode/hold to every output; all outputs registered.
// Backpressure: none; free-running, outputs refresh on every rising clk.
module mux_scan_nx1 #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 1,
    parameter int DWELL  = 100_000_000,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [SEL_W-1:0]         sel_in,
    input  logic                     mode,
    input  logic                     hold,
    output logic [DATA_W-1:0]        data_out,
    output logic [SEL_W-1:0]         active_ch,
    output logic                     ch_change,
    output logic                     sel_err
);

    // Dwell counter only has to reach DWELL-1.
    localparam int CNT_W = $clog2(DWELL);

    // Channel count widened by one bit so it is representable even when
    // NUM_CH is an exact power of two.
    localparam logic [SEL_W:0]   NUM_CH_EXT = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DWELL - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   dwell_cnt;

    logic               sel_valid;
    logic [SEL_W-1:0]   next_ch;
    logic [CNT_W-1:0]   next_cnt;
    logic               next_err;
    logic [DATA_W-1:0]  next_data;

    assign sel_valid = ({1'b0, sel_in} < NUM_CH_EXT);

    // Channel/counter decision for this edge. mode is acted on directly, so a
    // falling mode always wins over a coincident terminal count, and the entry
    // edge into scan just clears the counter and keeps the current channel.
    always_comb begin
        next_ch  = active_ch;
        next_cnt = dwell_cnt;
        next_err = 1'b0;
        if (!mode) begin
            next_cnt = '0;
            if (sel_valid) begin
                next_ch = sel_in;
            end else begin
                next_err = 1'b1;
            end
        end else if (state == MANUAL) begin
            next_cnt = '0;
        end else if (!hold) begin
            if (dwell_cnt == CNT_LAST) begin
                next_cnt = '0;
                next_ch  = (active_ch == LAST_CH) ? '0 : active_ch + 1'b1;
            end else begin
                next_cnt = dwell_cnt + 1'b1;
            end
        end
    end

    // Pick the channel that active_ch is about to take, so data_out and
    // active_ch always describe the same channel.
    always_comb begin
        next_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (next_ch == SEL_W'(k)) begin
                next_data = data_in[k*DATA_W +: DATA_W];
            end
        end
    end

    // Mode FSM plus every registered output; reset discards any partial dwell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= MANUAL;
            dwell_cnt <= '0;
            active_ch <= '0;
            data_out  <= '0;
            ch_change <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            state     <= mode ? SCAN : MANUAL;
            dwell_cnt <= next_cnt;
            active_ch <= next_ch;
            data_out  <= next_data;
            ch_change <= (next_ch != active_ch);
            sel_err   <= next_err;
        end
    end

endmodule

// File: tb/tb_mux_scan_nx1.sv
module tb_mux_scan_nx1;

    localparam int DW = 4;

    logic        clk = 1'b0;
    logic        rst;

    logic [15:0] d4_data;
    logic [1:0]  d4_sel;
    logic        d4_mode, d4_hold;
    logic [3:0]  d4_out;
    logic [1:0]  d4_ch;
    logic        d4_chg, d4_err;

    logic [11:0] d3_data;
    logic [1:0]  d3_sel;
    logic        d3_mode, d3_hold;
    logic [3:0]  d3_out;
    logic [1:0]  d3_ch;
    logic        d3_chg, d3_err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux_scan_nx1 #(.NUM_CH(4), .DATA_W(4), .DWELL(DW)) u_dut4 (
        .clk(clk), .rst(rst), .data_in(d4_data), .sel_in(d4_sel),
        .mode(d4_mode), .hold(d4_hold), .data_out(d4_out),
        .active_ch(d4_ch), .ch_change(d4_chg), .sel_err(d4_err)
    );

    mux_scan_nx1 #(.NUM_CH(3), .DATA_W(4), .DWELL(DW)) u_dut3 (
        .clk(clk), .rst(rst), .data_in(d3_data), .sel_in(d3_sel),
        .mode(d3_mode), .hold(d3_hold), .data_out(d3_out),
        .active_ch(d3_ch), .ch_change(d3_chg), .sel_err(d3_err)
    );

    // Reference model: one entry per DUT (0 = 4 channels, 1 = 3 channels).
    bit         m_scan [2];
    int         m_ch   [2];
    int         m_cnt  [2];
    logic [3:0] m_out  [2];
    bit         m_chg  [2];
    bit         m_err  [2];

    task automatic model_reset(input int i);
        m_scan[i] = 0; m_ch[i] = 0; m_cnt[i] = 0;
        m_out[i] = 4'h0; m_chg[i] = 0; m_err[i] = 0;
    endtask

    task automatic model_edge(input int i, input int nch, input bit mode, input bit hold,
                              input int sel, input logic [15:0] data);
        int nxt  = m_ch[i];
        int ncnt = m_cnt[i];
        bit err  = 0;
        if (!mode) begin
            ncnt = 0;
            if (sel < nch) nxt = sel;
            else err = 1;
        end else if (!m_scan[i]) begin
            ncnt = 0;
        end else if (!hold) begin
            if (m_cnt[i] == DW - 1) begin
                ncnt = 0;
                nxt  = (m_ch[i] + 1) % nch;
            end else begin
                ncnt = m_cnt[i] + 1;
            end
        end
        m_chg[i]  = (nxt != m_ch[i]);
        m_ch[i]   = nxt;
        m_cnt[i]  = ncnt;
        m_scan[i] = mode;
        m_err[i]  = err;
        m_out[i]  = 4'((data >> (nxt * 4)) & 16'h000F);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock edge; model follows the same inputs; returns 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_edge(0, 4, d4_mode, d4_hold, int'(d4_sel), d4_data);
            model_edge(1, 3, d3_mode, d3_hold, int'(d3_sel), {4'h0, d3_data});
        end
        #1;
    endtask

    task automatic cmp_model(input string tag);
        check({tag, ".d4.out"}, 32'(d4_out), 32'(m_out[0]));
        check({tag, ".d4.ch"},  32'(d4_ch),  32'(m_ch[0]));
        check({tag, ".d4.chg"}, 32'(d4_chg), 32'(m_chg[0]));
        check({tag, ".d4.err"}, 32'(d4_err), 32'(m_err[0]));
        check({tag, ".d3.out"}, 32'(d3_out), 32'(m_out[1]));
        check({tag, ".d3.ch"},  32'(d3_ch),  32'(m_ch[1]));
        check({tag, ".d3.chg"}, 32'(d3_chg), 32'(m_chg[1]));
        check({tag, ".d3.err"}, 32'(d3_err), 32'(m_err[1]));
    endtask

    task automatic chk4(input string tag, input logic [3:0] eo, input logic [1:0] ec,
                        input logic eg, input logic ee);
        check({tag, ".out"}, 32'(d4_out), 32'(eo));
        check({tag, ".ch"},  32'(d4_ch),  32'(ec));
        check({tag, ".chg"}, 32'(d4_chg), 32'(eg));
        check({tag, ".err"}, 32'(d4_err), 32'(ee));
    endtask

    task automatic chk3(input string tag, input logic [3:0] eo, input logic [1:0] ec,
                        input logic eg, input logic ee);
        check({tag, ".out"}, 32'(d3_out), 32'(eo));
        check({tag, ".ch"},  32'(d3_ch),  32'(ec));
        check({tag, ".chg"}, 32'(d3_chg), 32'(eg));
        check({tag, ".err"}, 32'(d3_err), 32'(ee));
    endtask

    typedef struct {
        logic        rst;
        logic        mode;
        logic        hold;
        logic [1:0]  sel;
        logic [15:0] data;
        logic [3:0]  e_out;
        logic [1:0]  e_ch;
        logic        e_chg;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic m, input logic h,
                                input logic [1:0] s, input logic [15:0] d,
                                input logic [3:0] eo, input logic [1:0] ec,
                                input logic eg, input logic ee);
        vec_t v;
        v.rst = r; v.mode = m; v.hold = h; v.sel = s; v.data = d;
        v.e_out = eo; v.e_ch = ec; v.e_chg = eg; v.e_err = ee;
        return v;
    endfunction

    vec_t vt [19];

    initial begin
        // Reset, manual select, scan with wrap, return to manual (4 channels, data D,C,B,A).
        vt[0]  = mk(1, 0, 0, 2'd2, 16'hDCBA, 4'h0, 2'd0, 0, 0);
        vt[1]  = mk(0, 0, 0, 2'd2, 16'hDCBA, 4'hC, 2'd2, 1, 0);
        vt[2]  = mk(0, 0, 0, 2'd2, 16'hDCBA, 4'hC, 2'd2, 0, 0);
        vt[3]  = mk(0, 0, 0, 2'd1, 16'hDCBA, 4'hB, 2'd1, 1, 0);
        vt[4]  = mk(0, 1, 0, 2'd1, 16'hDCBA, 4'hB, 2'd1, 0, 0);
        vt[5]  = mk(0, 1, 0, 2'd1, 16'hDCBA, 4'hB, 2'd1, 0, 0);
        vt[6]  = mk(0, 1, 0, 2'd1, 16'hDCBA, 4'hB, 2'd1, 0, 0);
        vt[7]  = mk(0, 1, 0, 2'd1, 16'hDCBA, 4'hB, 2'd1, 0, 0);
        vt[8]  = mk(0, 1, 0, 2'd1, 16'hDCBA, 4'hC, 2'd2, 1, 0);
        vt[9]  = mk(0, 1, 0, 2'd1, 16'hDCBA, 4'hC, 2'd2, 0, 0);
        vt[10] = mk(0, 1, 0, 2'd1, 16'hDCBA, 4'hC, 2'd2, 0, 0);
        vt[11] = mk(0, 1, 0, 2'd1, 16'hDCBA, 4'hC, 2'd2, 0, 0);
        vt[12] = mk(0, 1, 0, 2'd1, 16'hDCBA, 4'hD, 2'd3, 1, 0);
        vt[13] = mk(0, 1, 0, 2'd1, 16'hDCBA, 4'hD, 2'd3, 0, 0);
        vt[14] = mk(0, 1, 0, 2'd1, 16'hDCBA, 4'hD, 2'd3, 0, 0);
        vt[15] = mk(0, 1, 0, 2'd1, 16'hDCBA, 4'hD, 2'd3, 0, 0);
        vt[16] = mk(0, 1, 0, 2'd1, 16'hDCBA, 4'hA, 2'd0, 1, 0);
        vt[17] = mk(0, 0, 0, 2'd3, 16'hDCBA, 4'hD, 2'd3, 1, 0);
        vt[18] = mk(0, 0, 0, 2'd3, 16'h5CBA, 4'h5, 2'd3, 0, 0);

        rst = 1'b1;
        d4_data = 16'h0; d4_sel = 2'd0; d4_mode = 1'b0; d4_hold = 1'b0;
        d3_data = 12'h0; d3_sel = 2'd0; d3_mode = 1'b0; d3_hold = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        chk4("rst4", 4'h0, 2'd0, 0, 0);
        chk3("rst3", 4'h0, 2'd0, 0, 0);

        for (int i = 0; i < 19; i++) begin
            rst     = vt[i].rst;
            d4_mode = vt[i].mode;
            d4_hold = vt[i].hold;
            d4_sel  = vt[i].sel;
            d4_data = vt[i].data;
            step();
            chk4($sformatf("tbl%0d", i), vt[i].e_out, vt[i].e_ch, vt[i].e_chg, vt[i].e_err);
        end

        // Invalid select on the 3-channel instance.
        d3_data = 12'hCBA; d3_mode = 1'b0; d3_sel = 2'd1;
        step(); chk3("inv.sel1", 4'hB, 2'd1, 1, 0);
        d3_sel = 2'd3;
        step(); chk3("inv.sel3", 4'hB, 2'd1, 0, 1);
        d3_data = 12'hC5A;
        step(); chk3("inv.live", 4'h5, 2'd1, 0, 1);
        d3_sel = 2'd0;
        step(); chk3("inv.sel0", 4'hA, 2'd0, 1, 0);

        // Hold arriving on the terminal-count edge.
        d4_data = 16'hDCBA; d4_mode = 1'b0; d4_sel = 2'd2;
        step(); chk4("hold.pre", 4'hC, 2'd2, 1, 0);
        d4_mode = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk4("hold.term", 4'hC, 2'd2, 0, 0);
        d4_hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) d4_data = 16'hD7BA;
            step();
            check($sformatf("hold%0d.ch", i), 32'(d4_ch), 32'd2);
            check($sformatf("hold%0d.chg", i), 32'(d4_chg), 32'd0);
            check($sformatf("hold%0d.out", i), 32'(d4_out), (i >= 4) ? 32'h7 : 32'hC);
        end
        d4_hold = 1'b0;
        step(); chk4("hold.rel", 4'hD, 2'd3, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold.dw%0d.ch", i), 32'(d4_ch), 32'd3);
        end
        step(); chk4("hold.wrap", 4'hA, 2'd0, 1, 0);

        // mode falling on the terminal-count edge.
        d4_data = 16'hDCBA; d4_mode = 1'b0; d4_sel = 2'd1;
        step(); chk4("race.pre", 4'hB, 2'd1, 1, 0);
        d4_mode = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk4("race.term", 4'hB, 2'd1, 0, 0);
        d4_mode = 1'b0; d4_sel = 2'd0;
        step(); chk4("race.edge", 4'hA, 2'd0, 1, 0);
        d4_sel = 2'd2;
        step(); chk4("race.man", 4'hC, 2'd2, 1, 0);
        for (int i = 0; i < 5; i++) step();
        chk4("race.stay", 4'hC, 2'd2, 0, 0);

        // Asynchronous reset between edges mid-scan.
        d4_sel = 2'd3;
        step(); chk4("ar.pre", 4'hD, 2'd3, 1, 0);
        d4_mode = 1'b1;
        for (int i = 0; i < 3; i++) step();
        #2;
        rst = 1'b1;
        model_reset(0);
        model_reset(1);
        #1;
        chk4("ar.async4", 4'h0, 2'd0, 0, 0);
        chk3("ar.async3", 4'h0, 2'd0, 0, 0);
        step();
        rst = 1'b0;
        step(); chk4("ar.entry", 4'hA, 2'd0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("ar.dw%0d.ch", i), 32'(d4_ch), 32'd0);
        end
        step(); chk4("ar.adv", 4'hB, 2'd1, 1, 0);
        cmp_model("ar");

        // Randomised run on both instances against the model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 19) == 0) d4_mode = ~d4_mode;
            if ($urandom_range(0, 19) == 0) d3_mode = ~d3_mode;
            d4_hold = ($urandom_range(0, 3) == 0);
            d3_hold = ($urandom_range(0, 3) == 0);
            d4_sel  = 2'($urandom_range(0, 3));
            d3_sel  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) d4_data = 16'($urandom);
            if ($urandom_range(0, 3) == 0) d3_data = 12'($urandom);
            step();
            cmp_model($sformatf("rnd%0d", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
